interrupt_controller: RTL and testbench

Prioritised interrupt controller sitting directly upstream of the `RISC` processor: it collects up to `NUM_IRQ` external request lines and drives the processor's single `INT` input. It synchronises, latches and masks requests, then selects the highest-priority request. It presents a vector address and runs a request/acknowledge/end-of-interrupt handshake with the core. Only one interrupt is in service at a time; there is no nesting.

---
 rtl/interrupt_controller.sv | 134 +++++++++++++
 tb/tb_interrupt_controller.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_controller.sv
// Prioritised interrupt controller in front of the RISC core's INT input.
// Requests are synchronised, latched into a pending register, gated by the
// mask, and the lowest eligible index is offered with a REQ/ACK/EOI handshake.
// Build option: define IRQ_EDGE_TRIG_EN for edge-triggered pending bits;
// by default the pending register tracks the synchronised level.
module interrupt_controller #(
  parameter int unsigned NUM_IRQ  = 8,
  parameter logic [15:0] VEC_BASE = 16'h0040
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               int_ack,
  input  logic               eoi,
  output logic               INT,
  output logic [2:0]         int_id,
  output logic [15:0]        int_vector,
  output logic [NUM_IRQ-1:0] mask,
  output logic [NUM_IRQ-1:0] pending
);

  typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

  state_e             state_q, state_d;
  logic [NUM_IRQ-1:0] sync1_q, sync_q;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [NUM_IRQ-1:0] eligible;
  logic               int_q;
  logic [2:0]         id_q, id_d;
  logic [15:0]        vec_q, vec_d;
  logic [2:0]         win_id;
  logic               latch;

  // Two-flop synchroniser for the asynchronous request lines.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync_q  <= '0;
    end else begin
      sync1_q <= irq;
      sync_q  <= sync1_q;
    end
  end

`ifdef IRQ_EDGE_TRIG_EN
  logic [NUM_IRQ-1:0] sync_prev_q;
  logic [NUM_IRQ-1:0] set_vec, clr_vec;

  // Previous synchronised value, used to spot 0->1 transitions.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_prev_q <= '0;
    else      sync_prev_q <= sync_q;
  end

  // Edge mode: rising edge sets, accepted ack clears; a coincident set wins.
  always_comb begin
    set_vec = sync_q & ~sync_prev_q;
    clr_vec = '0;
    if (state_q == StReq && int_ack) clr_vec[id_q] = 1'b1;
    pending_d = (pending_q & ~clr_vec) | set_vec;
  end
`else
  // Level mode: pending simply follows the synchronised lines.
  always_comb begin
    pending_d = sync_q;
  end
`endif

  // Mask register write; mask only gates selection, never pending.
  always_comb begin
    mask_d   = mask_we ? mask_wdata : mask_q;
    eligible = pending_q & ~mask_q;
  end

  // Fixed priority: the lowest eligible index wins.
  always_comb begin
    win_id = '0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (eligible[i]) win_id = 3'(i);
    end
  end

  // Handshake FSM next state; id/vector latch only on IDLE->REQ.
  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|eligible) begin
          state_d = StReq;
          latch   = 1'b1;
        end
      end
      StReq: begin
        if (int_ack) state_d = StService;
      end
      StService: begin
        if (eoi) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    id_d  = latch ? win_id : id_q;
    vec_d = latch ? (VEC_BASE + {11'b0, win_id, 2'b00}) : vec_q;
  end

  // State, pending, mask and the registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      pending_q <= '0;
      mask_q    <= '0;
      int_q     <= 1'b0;
      id_q      <= '0;
      vec_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      int_q     <= (state_d == StReq);
      id_q      <= id_d;
      vec_q     <= vec_d;
    end
  end

  assign INT        = int_q;
  assign int_id     = id_q;
  assign int_vector = vec_q;
  assign mask       = mask_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller; follows IRQ_EDGE_TRIG_EN like the DUT.
module tb_interrupt_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  irq;
  logic        mask_we;
  logic [7:0]  mask_wdata;
  logic        int_ack;
  logic        eoi;
  logic        int_o;
  logic [2:0]  int_id;
  logic [15:0] int_vector;
  logic [7:0]  mask;
  logic [7:0]  pending;

  int n_cmp = 0;
  int n_err = 0;

  interrupt_controller #(
    .NUM_IRQ (8),
    .VEC_BASE(16'h0040)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .irq       (irq),
    .mask_we   (mask_we),
    .mask_wdata(mask_wdata),
    .int_ack   (int_ack),
    .eoi       (eoi),
    .INT       (int_o),
    .int_id    (int_id),
    .int_vector(int_vector),
    .mask      (mask),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; irq = '0; mask_we = 1'b0; mask_wdata = '0; int_ack = 1'b0; eoi = 1'b0;
    step(2);
    check("rst_int", 16'(int_o), 16'h0);
    check("rst_id", 16'(int_id), 16'h0);
    check("rst_vec", int_vector, 16'h0000);
    check("rst_mask", 16'(mask), 16'h0);
    check("rst_pend", 16'(pending), 16'h0);
    rst = 1'b1;
    step(1);

    // Latency: irq sampled at edge k -> pending after k+2, INT after k+3.
    irq = 8'h04;
    step(2);
    check("lat_pend_k1", 16'(pending), 16'h00);
    step(1);
    check("lat_pend_k2", 16'(pending), 16'h04);
    check("lat_int_k2", 16'(int_o), 16'h0);
    step(1);
    check("lat_int_k3", 16'(int_o), 16'h1);
    check("lat_id", 16'(int_id), 16'h2);
    check("lat_vec", int_vector, 16'h0048);

    // Stray eoi in REQ is ignored.
    eoi = 1'b1; step(1); eoi = 1'b0;
    check("eoi_req_int", 16'(int_o), 16'h1);
    check("eoi_req_id", 16'(int_id), 16'h2);

    irq = 8'h00; int_ack = 1'b1; step(1); int_ack = 1'b0;
    check("ack2_int", 16'(int_o), 16'h0);
`ifdef IRQ_EDGE_TRIG_EN
    check("ack2_pend", 16'(pending), 16'h00);
`else
    check("ack2_pend", 16'(pending), 16'h04);
`endif
    step(3);
    check("drain2_pend", 16'(pending), 16'h00);
    eoi = 1'b1; step(1); eoi = 1'b0;
    check("eoi2_int_n", 16'(int_o), 16'h0);
    step(1);
    check("eoi2_int_n1", 16'(int_o), 16'h0);

    // Stray ack in IDLE is ignored.
    int_ack = 1'b1; step(1); int_ack = 1'b0;
    check("ack_idle_int", 16'(int_o), 16'h0);
    check("ack_idle_pend", 16'(pending), 16'h00);

    // Priority: 0x90 -> id 4 first.
    irq = 8'h90;
    step(4);
    check("pri_int", 16'(int_o), 16'h1);
    check("pri_id", 16'(int_id), 16'h4);
    check("pri_vec", int_vector, 16'h0050);
    irq = 8'h00; int_ack = 1'b1; step(1); int_ack = 1'b0;
    check("pri_ack_int", 16'(int_o), 16'h0);
`ifdef IRQ_EDGE_TRIG_EN
    check("pri_ack_pend", 16'(pending), 16'h80);
    step(3);
    eoi = 1'b1; step(1); eoi = 1'b0;
    check("pri_eoi_n", 16'(int_o), 16'h0);
    step(1);
    check("pri_eoi_n1", 16'(int_o), 16'h1);
    check("pri_id7", 16'(int_id), 16'h7);
    check("pri_vec7", int_vector, 16'h005C);
    int_ack = 1'b1; step(1); int_ack = 1'b0;
    check("pri7_ack_pend", 16'(pending), 16'h00);
    eoi = 1'b1; step(1); eoi = 1'b0;
`else
    check("pri_ack_pend", 16'(pending), 16'h90);
    step(3);
    check("pri_drain", 16'(pending), 16'h00);
    eoi = 1'b1; step(1); eoi = 1'b0;
    check("pri_eoi_n", 16'(int_o), 16'h0);
    step(1);
    check("pri_eoi_n1", 16'(int_o), 16'h0);
`endif

    // Mask: masked request still pends but is not offered.
    mask_we = 1'b1; mask_wdata = 8'h01; step(1); mask_we = 1'b0;
    check("mask_rd", 16'(mask), 16'h01);
    irq = 8'h01;
    step(3);
    check("mask_pend", 16'(pending), 16'h01);
    step(2);
    check("mask_int", 16'(int_o), 16'h0);
    mask_we = 1'b1; mask_wdata = 8'h00; step(1); mask_we = 1'b0;
    check("unmask_w_int", 16'(int_o), 16'h0);
    step(1);
    check("unmask_int", 16'(int_o), 16'h1);
    check("unmask_id", 16'(int_id), 16'h0);
    check("unmask_vec", int_vector, 16'h0040);
    irq = 8'h00; int_ack = 1'b1; step(1); int_ack = 1'b0;
    step(3);
    check("unmask_drain", 16'(pending), 16'h00);
    eoi = 1'b1; step(2); eoi = 1'b0;
    check("unmask_idle", 16'(int_o), 16'h0);

`ifdef IRQ_EDGE_TRIG_EN
    // New irq[3] edge lands on the same edge as the ack of id 3: set wins.
    irq = 8'h08; step(1); irq = 8'h00;
    step(3);
    check("sim_int", 16'(int_o), 16'h1);
    check("sim_id", 16'(int_id), 16'h3);
    irq = 8'h08; step(1); irq = 8'h00;
    step(1);
    int_ack = 1'b1; step(1); int_ack = 1'b0;
    check("sim_ack_int", 16'(int_o), 16'h0);
    check("sim_pend", 16'(pending), 16'h08);
    eoi = 1'b1; step(1); eoi = 1'b0;
    step(1);
    check("sim_rereq", 16'(int_o), 16'h1);
    int_ack = 1'b1; step(1); int_ack = 1'b0;
    eoi = 1'b1; step(1); eoi = 1'b0;
`else
    // Level mode: a line held through eoi is re-raised at n+1.
    irq = 8'h02;
    step(4);
    check("lvl_int", 16'(int_o), 16'h1);
    check("lvl_id", 16'(int_id), 16'h1);
    int_ack = 1'b1; step(1); int_ack = 1'b0;
    check("lvl_ack_int", 16'(int_o), 16'h0);
    check("lvl_ack_pend", 16'(pending), 16'h02);
    eoi = 1'b1; step(1); eoi = 1'b0;
    check("lvl_eoi_n", 16'(int_o), 16'h0);
    step(1);
    check("lvl_eoi_n1", 16'(int_o), 16'h1);
    check("lvl_eoi_id", 16'(int_id), 16'h1);
    irq = 8'h00; int_ack = 1'b1; step(1); int_ack = 1'b0;
    step(3);
    eoi = 1'b1; step(1); eoi = 1'b0;
`endif

    // Asynchronous reset in the middle of REQ.
    mask_we = 1'b1; mask_wdata = 8'h80; step(1); mask_we = 1'b0;
    irq = 8'h20;
    step(4);
    check("pre_rst_int", 16'(int_o), 16'h1);
    check("pre_rst_id", 16'(int_id), 16'h5);
    check("pre_rst_vec", int_vector, 16'h0054);
    #2 rst = 1'b0;
    #1;
    check("arst_int", 16'(int_o), 16'h0);
    check("arst_pend", 16'(pending), 16'h00);
    check("arst_mask", 16'(mask), 16'h00);
    check("arst_vec", int_vector, 16'h0000);
    irq = 8'h00;
    step(1);
    rst = 1'b1;
    step(4);
    check("post_rst_int", 16'(int_o), 16'h0);
    check("post_rst_pend", 16'(pending), 16'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
